uart_tx_fifo: RTL and testbench
===============================

Name:
uart_tx_fifo

Overview:
Next-generation UART transmitter with a built-in transmit FIFO and runtime frame configuration. Supported frame options:
- 5 to 8 data bits
- parity none, odd or even
- 1 or 2 stop bits
- runtime baud divisor

Sits between a byte-producing controller (valid/ready handshake) and the serial TX pin. Frames sent back-to-back with no idle gap while the FIFO holds data.

Parameters:
DIV_W, 16, width of baud divisor input
FIFO_DEPTH, 16, FIFO entries; power of 2, >=2
FIFO_AW, 4, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
baud_div  input  DIV_W  clocks per bit; values 0 and 1 treated as 2
data_bits  input  2  data bits per frame: 0=5, 1=6, 2=7, 3=8
parity_mode  input  2  0=none, 1=odd, 2=even, 3=none
stop2  input  1  0=one stop bit, 1=two stop bits
tx_data  input  8  byte to queue; bits above the data width are ignored
tx_valid  input  1  tx_data valid
tx_ready  output  1  FIFO can accept (= not full)
tx_busy  output  1  high while a frame is on the line
uart_tx  output  1  serial line, idle high
tx_done  output  1  one-cycle pulse on the last clock of the final stop bit
fifo_level  output  FIFO_AW+1  entries currently queued

Behaviour:
Reset values:
- uart_tx=1, tx_busy=0, tx_done=0, tx_ready=1, fifo_level=0
- FSM=IDLE, FIFO pointers cleared

Reset mid-frame:
- Line returns high immediately (asynchronous).
- Queued data is discarded.

FIFO:
- Write when tx_valid && tx_ready.
- tx_ready=0 when fifo_level==FIFO_DEPTH.
- When full, a write is refused even if a pop happens in the same cycle.
- Simultaneous write+pop when not full: level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Pop is never issued when empty.

Config latch:
- baud_div, data_bits, parity_mode and stop2 are captured together with the data on the pop.
- Changes to these inputs mid-frame do not affect the current frame.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - FIFO non-empty -> pop, latch, go to START.
  - The pop cycle is the cycle after the write, so uart_tx falls 2 clocks after an accepted write into an empty FIFO while idle.
- START: uart_tx=0 for baud_div clocks -> DATA.
- DATA:
  - LSB first; each bit held baud_div clocks.
  - After N bits: parity enabled -> PARITY, else -> STOP.
- PARITY:
  - Odd mode: the bit makes the count of ones in (data + parity) odd.
  - Even mode: the count is even.
  - Held baud_div clocks -> STOP.
- STOP:
  - uart_tx=1 for baud_div clocks (1 stop bit) or 2*baud_div clocks (2 stop bits).
  - On the last clock, tx_done=1.
  - If the FIFO is non-empty, pop in that same cycle and enter START next clock (no idle gap); else -> IDLE.

Timing:
- Bit counter counts 0..baud_div-1 and restarts on every bit boundary.
- Frame length in clocks = baud_div*(1+N+P+S), where N=data bits, P=0/1 for parity, S=1/2 for stop bits.
- tx_busy is high from START entry through the last STOP clock; it stays high across back-to-back frames.
- uart_tx is registered and glitch-free.

Test Plan:
- Reset, then baud_div=4, 8N1, write 0x55 -> uart_tx falls 2 clocks after the write; line bits 0,1,0,1,0,1,0,1,0,1 each held 4 clocks; tx_done pulses at clock 40 of the frame; tx_busy drops the next clock.
- baud_div=1 (clamped to 2), 7 data bits, even parity, 2 stop bits, data 0x83 -> data bits 1,1,0,0,0,0,0; parity=0; line high for 4 clocks; frame = 2*11 = 22 clocks.
- 5 data bits, odd parity, data 0xFF -> data bits 1,1,1,1,1; parity=0 (5 ones already odd); upper 3 bits not sent.
- Write 18 bytes back-to-back, tx_valid held high, baud_div=2, 8N1 -> tx_ready drops once fifo_level reaches 16; all bytes transmitted in order; consecutive start bits exactly 20 clocks apart; tx_busy continuously high; final fifo_level=0.
- Change baud_div 4->8 and parity_mode during a frame -> current frame keeps 4-clock bits and its original parity; next frame uses 8-clock bits.
- Assert rst_n low mid-data-bit with 3 bytes queued -> uart_tx=1 and fifo_level=0 immediately; nothing transmitted after release until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a transmit FIFO and per-frame configuration.
//   clk, rst_n       : clock, asynchronous active-low reset
//   baud_div         : clocks per bit (0 and 1 act as 2)
//   data_bits        : 0..3 -> 5..8 data bits
//   parity_mode      : 0/3 none, 1 odd, 2 even
//   stop2            : two stop bits when high
//   tx_data/tx_valid : byte input, accepted when tx_ready is high
//   tx_ready         : FIFO not full
//   tx_busy          : frame on the line
//   uart_tx          : registered serial output, idle high
//   tx_done          : pulse on the last clock of the final stop bit
//   fifo_level       : entries queued
module uart_tx_fifo #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   baud_div,
    input  logic [1:0]         data_bits,
    input  logic [1:0]         parity_mode,
    input  logic               stop2,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_busy,
    output logic               uart_tx,
    output logic               tx_done,
    output logic [FIFO_AW:0]   fifo_level
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;
    logic [7:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] level;
    logic push, pop, empty;
    logic [DIV_W-1:0] div_l, cnt;
    logic [1:0] dbits_l;
    logic par_en_l, par_bit_l, stop2_l;
    logic [7:0] shreg, head, masked;
    logic [2:0] bit_cnt;
    logic bit_end, last_data, last_stop, frame_end, line_nx;

    assign empty      = level == '0;
    assign tx_ready   = level != (FIFO_AW+1)'(FIFO_DEPTH);
    assign push       = tx_valid && tx_ready;
    assign fifo_level = level;
    assign head       = mem[rd_ptr];
    assign masked     = head & (8'hFF >> (3'd3 - {1'b0, data_bits}));
    assign bit_end    = cnt == div_l - 1'b1;
    assign last_data  = bit_cnt == 3'd4 + {1'b0, dbits_l};
    assign last_stop  = bit_cnt == {2'b0, stop2_l};
    assign frame_end  = state == STOP && bit_end && last_stop;
    // The next frame is popped on the final stop clock so frames run back-to-back.
    assign pop        = !empty && (state == IDLE || frame_end);

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = START;
            START:   if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && last_data) state_nx = par_en_l ? PARITY : STOP;
            PARITY:  if (bit_end) state_nx = STOP;
            STOP:    if (frame_end) state_nx = empty ? IDLE : START;
            default: state_nx = IDLE;
        endcase
    end

    // Configuration and parity are captured with the byte so mid-frame input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_l     <= DIV_W'(2);
            dbits_l   <= '0;
            par_en_l  <= 1'b0;
            par_bit_l <= 1'b0;
            stop2_l   <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
        end else if (pop) begin
            div_l     <= (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
            dbits_l   <= data_bits;
            par_en_l  <= parity_mode[0] ^ parity_mode[1];
            par_bit_l <= ^masked ^ (parity_mode == 2'd1);
            stop2_l   <= stop2;
            shreg     <= head;
            cnt       <= '0;
            bit_cnt   <= '0;
        end else if (state != IDLE) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (bit_end) begin
                bit_cnt <= (state_nx != state) ? '0 : bit_cnt + 1'b1;
                if (state == DATA) shreg <= shreg >> 1;
            end
        end
    end

    always_comb
        line_nx = state == START  ? 1'b0 :
                  state == DATA   ? shreg[0] :
                  state == PARITY ? par_bit_l : 1'b1;

    // Outputs are registered, so the line trails the state by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            uart_tx <= line_nx;
            tx_busy <= state != IDLE;
            tx_done <= frame_end;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [1:0] data_bits = 2'd3;
    logic [1:0] parity_mode = 2'd0;
    logic stop2 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_valid = 1'b0;
    logic tx_ready, tx_busy, uart_tx, tx_done;
    logic [4:0] fifo_level;

    uart_tx_fifo dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_bits(data_bits),
        .parity_mode(parity_mode), .stop2(stop2), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .uart_tx(uart_tx), .tx_done(tx_done),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int div;
        int nb;
        int par;
        int s2;
    } exp_t;

    exp_t sb[$];
    int starts[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, wr_cyc = 0, last_start = 0, nframes = 0;
    int obs_len = 0, rdy_err = 0, max_level = 0;
    logic [7:0] obs_data = 8'h00;
    logic obs_par = 1'b0;
    logic in_frame = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int eff_div(input int d);
        return d < 2 ? 2 : d;
    endfunction

    task automatic push_exp(input logic [7:0] d, input int div, input int nb, input int par, input int s2);
        exp_t e;
        e.data = d; e.div = div; e.nb = nb; e.par = par; e.s2 = s2;
        sb.push_back(e);
    endtask

    task automatic set_cfg(input int div, input int db, input int par, input int s2);
        baud_div = 16'(div); data_bits = 2'(db); parity_mode = 2'(par); stop2 = 1'(s2);
    endtask

    // Called at a negedge; returns at the negedge after the write is accepted, tx_valid left high.
    task automatic send(input logic [7:0] d, input bit do_push);
        int t = 0;
        tx_data = d;
        tx_valid = 1'b1;
        while (!tx_ready && t < 1000) begin @(negedge clk); t++; end
        if (!tx_ready) check("ready_timeout", 0, 1);
        if (do_push) push_exp(d, eff_div(int'(baud_div)), int'(data_bits) + 5, int'(parity_mode), int'(stop2));
        @(posedge clk);
        #1 wr_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end
        while (!(sb.size() == 0 && !in_frame && !tx_busy && fifo_level == 0) && t < 5000);
        if (t >= 5000) check("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    // Decodes one frame starting at the current negedge against the head of the scoreboard.
    task automatic frame();
        exp_t e;
        int nb, np, L, j, errs, dcnt, dpos, busy_lo;
        logic [7:0] md, got;
        logic pb, gotp;
        logic bits [12];
        if (sb.size() == 0) begin
            check("unexpected_frame", 1, 0);
            @(negedge clk);
            return;
        end
        e = sb.pop_front();
        nb = e.nb;
        np = (e.par == 1 || e.par == 2) ? 1 : 0;
        md = e.data & 8'((1 << nb) - 1);
        pb = (e.par == 1) ? ($countones(md) % 2 == 0) : ($countones(md) % 2 == 1);
        L = e.div * (1 + nb + np + 1 + e.s2);
        for (int i = 0; i < 12; i++) bits[i] = 1'b1;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1+i] = md[i];
        if (np == 1) bits[1+nb] = pb;
        in_frame = 1'b1;
        last_start = cyc;
        starts.push_back(cyc);
        nframes++;
        errs = 0; dcnt = 0; dpos = -1; busy_lo = 0; got = 8'h00; gotp = 1'b0;
        for (int k = 0; k < L; k++) begin
            if (!rst_n) begin
                in_frame = 1'b0;
                return;
            end
            j = k / e.div;
            if (uart_tx !== bits[j]) errs++;
            if (k % e.div == e.div / 2) begin
                if (j >= 1 && j <= nb) got[j-1] = uart_tx;
                if (np == 1 && j == nb + 1) gotp = uart_tx;
            end
            if (tx_done) begin dcnt++; dpos = k; end
            if (!tx_busy) busy_lo++;
            @(negedge clk);
        end
        in_frame = 1'b0;
        obs_data = got;
        obs_par = gotp;
        obs_len = dpos + 1;
        check("frame_data", int'(got), int'(md));
        if (np == 1) check("frame_parity", int'(gotp), int'(pb));
        check("frame_line_errs", errs, 0);
        check("frame_done_pos", dpos, L - 1);
        check("frame_done_cnt", dcnt, 1);
        check("frame_busy_low", busy_lo, 0);
    endtask

    initial forever begin
        if (rst_n === 1'b1 && uart_tx === 1'b0) frame();
        else @(negedge clk);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (tx_ready !== (fifo_level != 5'd16)) rdy_err++;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, s0, bad, n0, lows;
        #23;
        check("rst_uart_tx", int'(uart_tx), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done), 0);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_level", int'(fifo_level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, divisor 4, 0x55
        set_cfg(4, 3, 0, 0);
        send(8'h55, 1);
        tx_valid = 1'b0;
        t = 0;
        while (!tx_done && t < 200) begin @(negedge clk); t++; end
        check("t1_done_seen", int'(tx_done), 1);
        check("t1_latency", last_start - wr_cyc, 2);
        check("t1_done_clk", cyc - last_start + 1, 40);
        @(negedge clk);
        check("t1_busy_drop", int'(tx_busy), 0);
        wait_idle();

        // divisor 1 clamps to 2, 7E2, 0x83
        set_cfg(1, 2, 2, 1);
        send(8'h83, 1);
        tx_valid = 1'b0;
        wait_idle();
        check("t2_len", obs_len, 22);
        check("t2_data", int'(obs_data), 8'h03);
        check("t2_parity", int'(obs_par), 0);

        // 5O1, 0xFF
        set_cfg(4, 0, 1, 0);
        send(8'hFF, 1);
        tx_valid = 1'b0;
        wait_idle();
        check("t3_len", obs_len, 32);
        check("t3_data", int'(obs_data), 8'h1F);
        check("t3_parity", int'(obs_par), 0);

        // 18 bytes back-to-back, divisor 2, 8N1
        set_cfg(2, 3, 0, 0);
        s0 = starts.size();
        for (int i = 0; i < 18; i++) send(8'(i * 37 + 11), 1);
        tx_valid = 1'b0;
        wait_idle();
        check("t4_frames", starts.size() - s0, 18);
        bad = 0;
        for (int i = s0 + 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != 20) bad++;
        check("t4_spacing_bad", bad, 0);
        check("t4_max_level", max_level, 16);
        check("t4_ready_rule_err", rdy_err, 0);
        check("t4_final_level", int'(fifo_level), 0);

        // config change mid-frame
        set_cfg(4, 3, 1, 0);
        send(8'hA5, 1);
        send(8'h3C, 0);
        push_exp(8'h3C, 8, 8, 2, 0);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        baud_div = 16'd8;
        parity_mode = 2'd2;
        s0 = starts.size();
        wait_idle();
        check("t5_frames", starts.size() - s0, 1);
        check("t5_first_len", starts[starts.size()-1] - starts[starts.size()-2], 44);
        check("t5_second_len", obs_len, 88);

        // reset mid data bit with 3 bytes queued
        set_cfg(8, 3, 0, 0);
        send(8'h00, 1);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        tx_valid = 1'b0;
        t = 0;
        while (!in_frame && t < 100) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        check("t6_level_pre", int'(fifo_level), 3);
        check("t6_line_pre", int'(uart_tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_line_rst", int'(uart_tx), 1);
        check("t6_level_rst", int'(fifo_level), 0);
        check("t6_busy_rst", int'(tx_busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = nframes;
        lows = 0;
        repeat (100) begin @(negedge clk); if (!uart_tx) lows++; end
        check("t6_idle_lows", lows, 0);
        check("t6_no_frames", nframes - n0, 0);
        send(8'h5A, 1);
        tx_valid = 1'b0;
        wait_idle();
        check("t6_after_frames", nframes - n0, 1);
        check("t6_after_data", int'(obs_data), 8'h5A);
        check("final_ready_rule_err", rdy_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
